pool_result_buffer: RTL and testbench
=====================================

POOL_RESULT_BUFFER -- requirements
Module: pool_result_buffer

Interface
REQ-001 Parameter W, default 4: data width of pooled values, matching the pooling ALU width.
REQ-002 Parameter WIN, default 4: number of ALU max samples reduced into one pooled result, range 1..16.
REQ-003 Parameter DEPTH, default 8: result FIFO entries, power of two, minimum 2.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 inValid  input  1  inData holds a valid ALU max sample.
REQ-007 inData  input  W  unsigned max value from the pooling ALU.
REQ-008 inReady  output  1  block accepts a sample this cycle.
REQ-009 outValid  output  1  outData holds the FIFO head result.
REQ-010 outData  output  W  pooled result at the FIFO head.
REQ-011 outReady  input  1  consumer accepts outData this cycle.

Function
REQ-012 Accept the input when inValid and inReady are both high at a rising CLK edge.
REQ-013 inReady SHALL equal NOT full, decoded from registered FIFO level only, with no combinational path from inValid or outReady.
REQ-014 Window counter cnt runs 0..WIN-1 and advances only on accept; at WIN-1 it returns to 0.
REQ-015 On accept with cnt==0 and WIN>1, the accumulator acc loads inData.
REQ-016 On accept with 0<cnt<WIN-1, acc loads the unsigned max of acc and inData.
REQ-017 On accept with cnt==WIN-1, the block writes the unsigned max of acc and inData into the FIFO tail in that same edge.
REQ-018 When WIN==1, each accepted sample is written to the FIFO directly.
REQ-019 Equal values: the max SHALL return that value; no tie-break state.
REQ-020 Write-to-output latency is exactly one cycle: outValid rises in the cycle after the completing accept edge, with no bypass.
REQ-021 Pop when outValid and outReady are both high at an edge.
REQ-022 outValid SHALL equal NOT empty, registered-level based.
REQ-023 outData SHALL equal the head entry when outValid is high and 0 when the FIFO is empty.
REQ-024 While outValid is high and outReady is low, outData SHALL remain stable.
REQ-025 On a simultaneous push and pop, the level SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, inReady is low, so no push and no loss occur; a pop in the full cycle raises inReady in the next cycle.
REQ-027 Pointers wrap modulo DEPTH; the level is tracked with log2(DEPTH)+1 bits.

Reset
REQ-028 When RST is high at an edge, the block SHALL clear cnt, acc, pointers and level to 0, and drive outValid 0, outData 0 and inReady 1 from the next cycle.
REQ-029 RST SHALL take priority over a simultaneous accept or pop.
REQ-030 RST mid-window SHALL discard the partial window; the next accepted sample starts a new window.

Configuration
REQ-031 With macro POOL_RESULT_BUFFER_STATUS_EN defined, the block SHALL add output level [log2(DEPTH):0], equal to the current FIFO occupancy.
REQ-032 With the macro defined, the block SHALL add output stallSeen (1 bit), a sticky flag set when inValid is high while inReady is low, cleared only by RST.
REQ-033 Without the macro, the level and stallSeen ports and their logic SHALL be absent; all other behaviour is identical.

Verification (W=4, WIN=4, DEPTH=8)
REQ-034 After reset, feed 1,7,3,2 on consecutive cycles with outReady=1 -> outValid is high with outData=7 for exactly one cycle, starting one cycle after the 4th accept.
REQ-035 With outReady=0, feed 8 windows -> inReady goes low after the 8th result push; a 33rd sample is held off; outData stays at the first result.
REQ-036 With level 3, complete a window in the same cycle as a pop -> level stays 3 and the results emerge in FIFO order.
REQ-037 Feed 9,9, assert RST for one cycle, then feed 1,2,3,4 -> the single result is 4, and outValid is 0 during and immediately after reset.
REQ-038 Hold outValid with outReady=0 for 5 cycles -> outData is constant; release -> the next head appears on the following cycle.
REQ-039 With POOL_RESULT_BUFFER_STATUS_EN defined, present inValid=1 while full -> stallSeen=1 and level=8; stallSeen stays 1 after draining until RST.

Source files
------------

// File: rtl/pool_result_buffer.sv
// pool_result_buffer: reduces WIN pooling-ALU max samples into one result
// and queues results in a DEPTH-entry FIFO with valid/ready on both sides.
//
// Ports:
//   CLK       in   clock, all state updates on the rising edge
//   RST       in   synchronous active-high reset
//   inValid   in   inData carries an ALU max sample
//   inData    in   [W-1:0] unsigned sample
//   inReady   out  FIFO not full (registered level only)
//   outValid  out  FIFO not empty (registered level only)
//   outData   out  [W-1:0] FIFO head, 0 when empty
//   outReady  in   consumer takes outData this cycle
//   level     out  [log2(DEPTH):0] occupancy  (POOL_RESULT_BUFFER_STATUS_EN)
//   stallSeen out  sticky "input offered while full" (POOL_RESULT_BUFFER_STATUS_EN)
//
// Optional status ports are enabled by defining POOL_RESULT_BUFFER_STATUS_EN.

module pool_result_buffer #(
    parameter int W     = 4,
    parameter int WIN   = 4,
    parameter int DEPTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inValid,
    input  logic [W-1:0] inData,
    output logic         inReady,
    output logic         outValid,
    output logic [W-1:0] outData,
`ifdef POOL_RESULT_BUFFER_STATUS_EN
    output logic [$clog2(DEPTH):0] level,
    output logic                   stallSeen,
`endif
    input  logic         outReady
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic          accept;
    logic          last;
    logic          push;
    logic          pop;
    logic [W-1:0]  max_v;
    logic [W-1:0]  push_data;

    // Handshake flags depend only on the registered level.
    assign inReady  = (level_q != LW'(DEPTH));
    assign outValid = (level_q != '0);
    assign outData  = outValid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        accept    = inValid && inReady;
        last      = (cnt_q == CW'(WIN - 1));
        max_v     = (acc_q > inData) ? acc_q : inData;
        push      = accept && last;
        // A single-sample window bypasses the accumulator entirely.
        push_data = (WIN == 1) ? inData : max_v;
        pop       = outValid && outReady;

        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (accept) begin
            if (last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = (cnt_q == '0) ? inData : max_v;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        // Simultaneous push and pop leaves the level unchanged.
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: outData is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push && !RST) mem_q[wr_ptr_q] <= push_data;
    end

`ifdef POOL_RESULT_BUFFER_STATUS_EN
    logic stall_seen_q, stall_seen_d;

    always_comb begin
        stall_seen_d = stall_seen_q | (inValid & ~inReady);
    end

    always_ff @(posedge CLK) begin
        if (RST) stall_seen_q <= 1'b0;
        else     stall_seen_q <= stall_seen_d;
    end

    assign level     = level_q;
    assign stallSeen = stall_seen_q;
`endif

endmodule

// File: tb/tb_pool_result_buffer.sv
// Self-checking bench for pool_result_buffer (W=4, WIN=4, DEPTH=8).
// Expected results are queued at stimulus time and popped by a monitor.

module tb_pool_result_buffer;

    logic       CLK;
    logic       RST;
    logic       inValid;
    logic [3:0] inData;
    logic       inReady;
    logic       outValid;
    logic [3:0] outData;
    logic       outReady;
`ifdef POOL_RESULT_BUFFER_STATUS_EN
    logic [3:0] level;
    logic       stallSeen;
`endif

    int total = 0;
    int bad   = 0;
    int sb[$];

    pool_result_buffer #(.W(4), .WIN(4), .DEPTH(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .inValid  (inValid),
        .inData   (inData),
        .inReady  (inReady),
        .outValid (outValid),
        .outData  (outData),
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        .level    (level),
        .stallSeen(stallSeen),
`endif
        .outReady (outReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: every pop observed at the DUT is checked against the queue.
    always @(negedge CLK) begin
        if (!RST && outValid && outReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", int'(outData), -1);
            end else begin
                chk("pop_data", int'(outData), sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic [3:0] v);
        inValid = 1'b1;
        inData  = v;
        step();
        inValid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || outValid); i++) begin
            step();
        end
        chk("drain_left", sb.size(), 0);
    endtask

    logic [3:0] win_tab [8][4] = '{
        '{4'd3,  4'd1,  4'd2,  4'd0},
        '{4'd0,  4'd0,  4'd0,  4'd0},
        '{4'd15, 4'd2,  4'd15, 4'd1},
        '{4'd4,  4'd9,  4'd8,  4'd9},
        '{4'd5,  4'd5,  4'd5,  4'd5},
        '{4'd1,  4'd2,  4'd3,  4'd6},
        '{4'd12, 4'd11, 4'd10, 4'd0},
        '{4'd0,  4'd0,  4'd0,  4'd14}
    };
    int win_exp [8] = '{3, 0, 15, 9, 5, 6, 12, 14};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;

        // Reset state
        step();
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_outValid", int'(outValid), 0);
        chk("rst_outData", int'(outData), 0);
        chk("rst_inReady", int'(inReady), 1);
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        chk("rst_level", int'(level), 0);
        chk("rst_stall", int'(stallSeen), 0);
`endif
        step();

        // Basic window: 1,7,3,2 -> 7, one-cycle latency, single beat
        outReady = 1'b1;
        sb.push_back(7);
        feed(4'd1);
        feed(4'd7);
        feed(4'd3);
        feed(4'd2);
        @(negedge CLK);
        chk("lat_outValid_hi", int'(outValid), 1);
        chk("lat_outData", int'(outData), 7);
        step();
        @(negedge CLK);
        chk("lat_outValid_lo", int'(outValid), 0);
        step();

        // Fill to full with 8 windows, consumer stalled
        outReady = 1'b0;
        for (int w = 0; w < 8; w++) begin
            sb.push_back(win_exp[w]);
            for (int s = 0; s < 4; s++) feed(win_tab[w][s]);
        end
        @(negedge CLK);
        chk("full_inReady", int'(inReady), 0);
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        chk("full_level", int'(level), 8);
`endif
        step();

        // 33rd sample is held off; head stays stable for 5 cycles
        inValid = 1'b1;
        inData  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_inReady", int'(inReady), 0);
            chk("hold_outData", int'(outData), 3);
            step();
        end
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        @(negedge CLK);
        chk("stall_set", int'(stallSeen), 1);
        chk("stall_level", int'(level), 8);
        step();
`endif
        inValid = 1'b0;

        // Pop in the full cycle raises inReady next cycle
        outReady = 1'b1;
        @(negedge CLK);
        chk("pop_full_inReady_lo", int'(inReady), 0);
        step();
        @(negedge CLK);
        chk("pop_full_inReady_hi", int'(inReady), 1);
        step();
        wait_drain();
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        @(negedge CLK);
        chk("stall_sticky", int'(stallSeen), 1);
        step();
`endif

        // Level 3, then complete a window on the same edge as a pop
        outReady = 1'b0;
        sb.push_back(1);
        sb.push_back(2);
        sb.push_back(3);
        sb.push_back(6);
        feed(4'd1); feed(4'd1); feed(4'd1); feed(4'd1);
        feed(4'd2); feed(4'd0); feed(4'd0); feed(4'd0);
        feed(4'd0); feed(4'd3); feed(4'd0); feed(4'd0);
        feed(4'd4); feed(4'd4); feed(4'd4);
        outReady = 1'b1;
        feed(4'd6);
        @(negedge CLK);
        chk("pushpop_outValid", int'(outValid), 1);
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        chk("pushpop_level", int'(level), 3);
`endif
        step();
        wait_drain();

        // Reset mid-window discards the partial window
        outReady = 1'b1;
        feed(4'd9);
        feed(4'd9);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outValid_during", int'(outValid), 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_outValid_after", int'(outValid), 0);
        chk("rst_mid_outData", int'(outData), 0);
        chk("rst_mid_inReady", int'(inReady), 1);
`ifdef POOL_RESULT_BUFFER_STATUS_EN
        chk("rst_mid_stall", int'(stallSeen), 0);
        chk("rst_mid_level", int'(level), 0);
`endif
        step();
        sb.push_back(4);
        feed(4'd1);
        feed(4'd2);
        feed(4'd3);
        feed(4'd4);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
